// File: rtl/coef_mac_sequencer.sv
// Time-multiplexed FIR controller: one 24x8 product per cycle from an external multiplier,
// accumulated over TAPS cycles and returned saturated to 32 bits over valid/ready.
module coef_mac_sequencer #(
    parameter int TAPS  = 8,
    parameter int ACC_W = 40
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     coef_we_i,
    input  logic [$clog2(TAPS)-1:0]  coef_addr_i,
    input  logic [7:0]               coef_wdata_i,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  logic [23:0]              in_data_i,
    output logic [23:0]              mul_a_o,
    output logic [7:0]               mul_b_o,
    input  logic [31:0]              mul_p_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [31:0]              out_data_o,
    output logic                     out_sat_o,
    output logic                     busy_o
);
    localparam int AW = $clog2(TAPS);
    localparam logic [AW-1:0] LAST_TAP = AW'(TAPS - 1);
    localparam logic signed [ACC_W-1:0] MAX_V = {{(ACC_W-31){1'b0}}, {31{1'b1}}};
    localparam logic signed [ACC_W-1:0] MIN_V = {{(ACC_W-31){1'b1}}, {31{1'b0}}};

    typedef enum logic [1:0] {IDLE, MAC, OUT} state_e;

    state_e                   state_q;
    logic [AW-1:0]            tap_q;
    logic signed [ACC_W-1:0]  acc_q;
    logic [23:0]              x_q    [TAPS];
    logic [7:0]               coef_q [TAPS];
    logic                     in_ready_q, out_valid_q, out_sat_q, busy_q;
    logic [31:0]              out_data_q;

    logic signed [ACC_W-1:0]  sum_d;
    logic [31:0]              sat_data_d;
    logic                     sat_flag_d;

    // Sum including the product of the current tap; on the last tap this is the final result.
    always_comb begin
        sum_d      = acc_q + {{(ACC_W-32){mul_p_i[31]}}, mul_p_i};
        sat_data_d = sum_d[31:0];
        sat_flag_d = 1'b0;
        if (sum_d > MAX_V) begin
            sat_data_d = 32'h7FFF_FFFF;
            sat_flag_d = 1'b1;
        end else if (sum_d < MIN_V) begin
            sat_data_d = 32'h8000_0000;
            sat_flag_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q     <= IDLE;
            tap_q       <= '0;
            acc_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sat_q   <= 1'b0;
            busy_q      <= 1'b0;
            for (int k = 0; k < TAPS; k++) begin
                x_q[k]    <= '0;
                coef_q[k] <= '0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    // Coefficients only change here, so a transaction sees a fixed set.
                    if (coef_we_i) coef_q[coef_addr_i] <= coef_wdata_i;
                    if (in_valid_i) begin
                        x_q[0] <= in_data_i;
                        for (int k = 1; k < TAPS; k++) x_q[k] <= x_q[k-1];
                        acc_q      <= '0;
                        tap_q      <= '0;
                        state_q    <= MAC;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                MAC: begin
                    acc_q <= sum_d;
                    tap_q <= tap_q + 1'b1;
                    if (tap_q == LAST_TAP) begin
                        state_q     <= OUT;
                        out_valid_q <= 1'b1;
                        out_data_q  <= sat_data_d;
                        out_sat_q   <= sat_flag_d;
                    end
                end
                OUT: begin
                    if (out_ready_i) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mul_a_o     = (state_q == MAC) ? x_q[tap_q]    : '0;
    assign mul_b_o     = (state_q == MAC) ? coef_q[tap_q] : '0;
    assign in_ready_o  = in_ready_q;
    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign out_sat_o   = out_sat_q;
    assign busy_o      = busy_q;
endmodule

// File: tb/tb_coef_mac_sequencer.sv
// Directed bench for coef_mac_sequencer with a behavioural 24x8 signed multiplier.
module tb_coef_mac_sequencer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        coef_we = 1'b0;
    logic [2:0]  coef_addr = '0;
    logic [7:0]  coef_wdata = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [23:0] in_data = '0;
    logic [23:0] mul_a;
    logic [7:0]  mul_b;
    logic signed [31:0] mul_p;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic        out_sat;
    logic        busy;

    int total = 0;
    int bad   = 0;

    coef_mac_sequencer #(.TAPS(8), .ACC_W(40)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .coef_we_i(coef_we), .coef_addr_i(coef_addr),
        .coef_wdata_i(coef_wdata), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .in_data_i(in_data), .mul_a_o(mul_a), .mul_b_o(mul_b), .mul_p_i(mul_p),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
        .out_sat_o(out_sat), .busy_o(busy)
    );

    assign mul_p = $signed(mul_a) * $signed(mul_b);

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic wr_coef(input logic [2:0] a, input logic [7:0] d);
        @(negedge clk);
        coef_we = 1'b1; coef_addr = a; coef_wdata = d;
        @(posedge clk);
        #1 coef_we = 1'b0;
    endtask

    task automatic push(input logic [23:0] d);
        @(negedge clk);
        in_valid = 1'b1; in_data = d;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // Counts falling edges from the accept until out_valid is seen.
    task automatic wait_valid(output int lat);
        lat = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            lat++;
            if (out_valid) break;
        end
        if (!out_valid) chk("timeout", 32'(out_valid), 32'd1);
    endtask

    task automatic take(output logic [31:0] d, output logic s);
        d = out_data; s = out_sat;
        @(negedge clk) out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    task automatic run(input logic [23:0] x, output logic [31:0] d, output logic s);
        int lat;
        push(x);
        wait_valid(lat);
        take(d, s);
    endtask

    initial begin
        int          lat;
        logic [31:0] d, d0;
        logic        s, s0, stale;

        // Reset state
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_mul_a", 32'(mul_a), 32'd0);

        // Zero coefficients, check latency
        push(24'd100);
        chk("mac_busy", 32'(busy), 32'd1);
        chk("mac_in_ready", 32'(in_ready), 32'd0);
        chk("mac_mul_a", 32'(mul_a), 32'd100);
        wait_valid(lat);
        chk("latency", 32'(lat), 32'd9);
        take(d, s);
        chk("zero_data", d, 32'd0);
        chk("zero_sat", 32'(s), 32'd0);
        chk("idle_in_ready", 32'(in_ready), 32'd1);
        chk("idle_out_valid", 32'(out_valid), 32'd0);

        // Impulse response
        do_reset();
        for (int k = 0; k < 8; k++) wr_coef(3'(k), 8'(k + 1));
        for (int k = 0; k < 8; k++) begin
            run((k == 0) ? 24'd1 : 24'd0, d, s);
            chk($sformatf("impulse%0d", k), d, 32'(k + 1));
        end

        // Saturation: (-2^23)*(-128) = 2^30 once, 2^31 twice
        for (int k = 0; k < 8; k++) wr_coef(3'(k), 8'h80);
        run(24'h800000, d, s);
        chk("sat1_data", d, 32'h4000_0000);
        chk("sat1_flag", 32'(s), 32'd0);

        // Second push saturates; hold it under backpressure
        push(24'h800000);
        wait_valid(lat);
        d0 = out_data; s0 = out_sat;
        chk("sat2_data", d0, 32'h7FFF_FFFF);
        chk("sat2_flag", 32'(s0), 32'd1);
        in_valid = 1'b1; in_data = 24'd5;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("bp_valid", 32'(out_valid), 32'd1);
            chk("bp_data", out_data, d0);
            chk("bp_sat", 32'(out_sat), 32'(s0));
            chk("bp_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        take(d, s);
        chk("bp_release_ready", 32'(in_ready), 32'd1);
        chk("bp_release_valid", 32'(out_valid), 32'd0);
        chk("bp_release_busy", 32'(busy), 32'd0);

        // Coefficient write while busy is ignored
        do_reset();
        wr_coef(3'd0, 8'd2);
        wr_coef(3'd1, 8'd7);
        push(24'd3);
        chk("busy_mul_b", 32'(mul_b), 32'd2);
        @(negedge clk);
        coef_we = 1'b1; coef_addr = 3'd0; coef_wdata = 8'd5;
        repeat (3) @(posedge clk);
        #1 coef_we = 1'b0;
        wait_valid(lat);
        take(d, s);
        chk("busy_wr_result", d, 32'd6);
        run(24'd0, d, s);
        chk("busy_wr_tap1", d, 32'd21);
        run(24'd1, d, s);
        chk("busy_wr_coef0_kept", d, 32'd2);

        // Reset in the middle of MAC at tap 4
        push(24'd9);
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_mul_a", 32'(mul_a), 32'd0);
        stale = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (out_valid) stale = 1'b1;
        end
        chk("midrst_no_stale", 32'(stale), 32'd0);
        run(24'd1, d, s);
        chk("midrst_coefs_cleared", d, 32'd0);

        // Coefficient write and accept in the same cycle: new coefficient is used
        @(negedge clk);
        coef_we = 1'b1; coef_addr = 3'd0; coef_wdata = 8'd3;
        in_valid = 1'b1; in_data = 24'd1;
        @(posedge clk);
        #1 coef_we = 1'b0; in_valid = 1'b0;
        wait_valid(lat);
        take(d, s);
        chk("same_cycle_wr", d, 32'd3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
